// File: rtl/sumador_pkg.sv
// Shared definitions for the adder/subtractor response checker and its golden model.
package sumador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sumador_restador_checker_if.sv
// Stimulus/response bundle between a stimulus source and the adder/subtractor checker.
interface sumador_restador_checker_if #(
  parameter int NBITS = 4,
  parameter int CNT_W = 16
);
  logic             iStart;
  logic             iEnd;
  logic             iValid;
  logic             iOp;
  logic [NBITS-1:0] iX;
  logic [NBITS-1:0] iY;
  logic [NBITS-1:0] iS;
  logic             iCout;
  logic             iOverflow;

  logic             oBusy;
  logic             oDone;
  logic             oPass;
  logic             oFail;
  logic [CNT_W-1:0] oCheckCnt;
  logic [CNT_W-1:0] oErrCnt;
  logic             oFirstOp;
  logic [NBITS-1:0] oFirstX;
  logic [NBITS-1:0] oFirstY;

  modport master (
    output iStart, iEnd, iValid, iOp, iX, iY, iS, iCout, iOverflow,
    input  oBusy, oDone, oPass, oFail, oCheckCnt, oErrCnt, oFirstOp, oFirstX, oFirstY
  );

  modport slave (
    input  iStart, iEnd, iValid, iOp, iX, iY, iS, iCout, iOverflow,
    output oBusy, oDone, oPass, oFail, oCheckCnt, oErrCnt, oFirstOp, oFirstX, oFirstY
  );
endinterface

// File: rtl/sumador_restador_ref.sv
// Combinational golden model of the N-bit adder/subtractor: X+Y or X+~Y+1.
module sumador_restador_ref
  import sumador_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic             iOp,
  input  logic [NBITS-1:0] iX,
  input  logic [NBITS-1:0] iY,
  output logic [NBITS-1:0] oS,
  output logic             oCout,
  output logic             oOverflow
);

  logic [NBITS-1:0] y_eff;
  logic [NBITS:0]   sum;

  // Two's-complement add with the subtrahend inverted and carry-in set for subtraction
  always_comb begin
    y_eff = iY;
    if (iOp == OP_SUB) begin
      y_eff = ~iY;
    end else begin
      y_eff = iY;
    end
    sum       = {1'b0, iX} + {1'b0, y_eff} + {{NBITS{1'b0}}, iOp};
    oS        = sum[NBITS-1:0];
    oCout     = sum[NBITS];
    oOverflow = (iX[NBITS-1] == y_eff[NBITS-1]) & (sum[NBITS-1] != iX[NBITS-1]);
  end

endmodule

// File: rtl/sumador_restador_checker.sv
// Response checker: captures a stimulus/response pair, compares it against the golden
// model one clock later, and keeps saturating check/error counts plus the first failure.
module sumador_restador_checker
  import sumador_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int CNT_W = 16
) (
  input  logic                      iClk,
  input  logic                      iRst,
  sumador_restador_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       state;
  logic             cap_valid;
  logic             cap_op;
  logic [NBITS-1:0] cap_x;
  logic [NBITS-1:0] cap_y;
  logic [NBITS-1:0] cap_s;
  logic             cap_cout;
  logic             cap_ovf;

  logic [CNT_W-1:0] check_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             fail;
  logic             first_op;
  logic [NBITS-1:0] first_x;
  logic [NBITS-1:0] first_y;

  logic [NBITS-1:0] exp_s;
  logic             exp_cout;
  logic             exp_ovf;
  logic             accept;
  logic             mismatch;

  sumador_restador_ref #(.NBITS(NBITS)) u_ref (
    .iOp       (cap_op),
    .iX        (cap_x),
    .iY        (cap_y),
    .oS        (exp_s),
    .oCout     (exp_cout),
    .oOverflow (exp_ovf)
  );

  // A sample arriving with iEnd is still accepted because the state is still RUN.
  assign accept   = (state == ST_RUN) & bus.iValid;
  assign mismatch = cap_valid & ({cap_s, cap_cout, cap_ovf} != {exp_s, exp_cout, exp_ovf});

  // FSM and stage-1 capture of the stimulus/response pair
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_IDLE;
      cap_valid <= 1'b0;
      cap_op    <= 1'b0;
      cap_x     <= {NBITS{1'b0}};
      cap_y     <= {NBITS{1'b0}};
      cap_s     <= {NBITS{1'b0}};
      cap_cout  <= 1'b0;
      cap_ovf   <= 1'b0;
    end else if (bus.iStart) begin
      state     <= ST_RUN;
      cap_valid <= 1'b0;
      cap_op    <= 1'b0;
      cap_x     <= {NBITS{1'b0}};
      cap_y     <= {NBITS{1'b0}};
      cap_s     <= {NBITS{1'b0}};
      cap_cout  <= 1'b0;
      cap_ovf   <= 1'b0;
    end else begin
      cap_valid <= accept;
      if (accept) begin
        cap_op   <= bus.iOp;
        cap_x    <= bus.iX;
        cap_y    <= bus.iY;
        cap_s    <= bus.iS;
        cap_cout <= bus.iCout;
        cap_ovf  <= bus.iOverflow;
      end
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_RUN:  state <= bus.iEnd ? ST_DONE : ST_RUN;
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Retire stage: saturating counters, sticky fail flag and first-mismatch latch
  always_ff @(posedge iClk) begin
    if (iRst || bus.iStart) begin
      check_cnt <= CNT_ZERO;
      err_cnt   <= CNT_ZERO;
      fail      <= 1'b0;
      first_op  <= 1'b0;
      first_x   <= {NBITS{1'b0}};
      first_y   <= {NBITS{1'b0}};
    end else if (cap_valid) begin
      if (check_cnt != CNT_MAX) begin
        check_cnt <= check_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mismatch) begin
        fail <= 1'b1;
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (err_cnt == CNT_ZERO) begin
          first_op <= cap_op;
          first_x  <= cap_x;
          first_y  <= cap_y;
        end
      end
    end
  end

  // oDone waits for the capture stage to drain so oPass reflects the final count.
  assign bus.oBusy     = (state == ST_RUN);
  assign bus.oDone     = (state == ST_DONE) & ~cap_valid;
  assign bus.oPass     = bus.oDone & (err_cnt == CNT_ZERO);
  assign bus.oFail     = fail;
  assign bus.oCheckCnt = check_cnt;
  assign bus.oErrCnt   = err_cnt;
  assign bus.oFirstOp  = first_op;
  assign bus.oFirstX   = first_x;
  assign bus.oFirstY   = first_y;

endmodule
